// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci term capture block.
package fib_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefIdxW  = 5;

  typedef enum logic [1:0] {
    StRestart,
    StStream,
    StWait
  } state_e;

  // First 13 terms that fit in 8 bits; index 13 (377) wraps to 121.
  localparam logic [7:0] FibRef [13] = '{
    8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233
  };

endpackage

// File: rtl/fib_fifo.sv
// First-word fall-through FIFO with occupancy count; storage is cleared on reset.
module fib_fifo #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rdata,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= wdata;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fib_term_capture.sv
// Captures generator terms into a FIFO, restarting the generator on 8-bit wrap
// and on backpressure, skipping forward so the consumer sees a gap-free series.
module fib_term_capture
  import fib_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned IDX_W  = DefIdxW,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] term_in,
  output logic              gen_restart,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [IDX_W-1:0]  m_index,
  output logic              seq_wrap
);

  localparam int unsigned CntW = $clog2(DEPTH+1);
  localparam logic [IDX_W-1:0] IdxMax = '1;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, resume_q, resume_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [CntW-1:0]   count;
  logic              full, wrap, accept, push, pop;

  // Full uses the registered count only; a same-cycle pop does not free a slot.
  assign full   = (count == CntW'(DEPTH));
  assign wrap   = (state_q == StStream) && (idx_q != '0) && (term_in < prev_q);
  assign accept = (idx_q >= resume_q);
  assign pop    = m_valid && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRestart;
      idx_q    <= '0;
      resume_q <= '0;
      prev_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      resume_q <= resume_d;
      prev_q   <= prev_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    resume_d = resume_q;
    prev_d   = prev_q;
    push     = 1'b0;
    unique case (state_q)
      StRestart: begin
        state_d = StStream;
        idx_d   = '0;
      end
      StStream: begin
        idx_d  = (idx_q == IdxMax) ? idx_q : idx_q + IDX_W'(1);
        prev_d = term_in;
        if (wrap) begin
          resume_d = '0;
          state_d  = StRestart;
        end else if (accept && full) begin
          // Resume from the first term that could not be stored.
          resume_d = idx_q;
          state_d  = StWait;
        end else if (accept) begin
          push = 1'b1;
        end
      end
      StWait: begin
        if (!full) state_d = StRestart;
      end
      default: state_d = StRestart;
    endcase
  end

  always_comb begin
    gen_restart = (state_q == StRestart);
    seq_wrap    = wrap;
  end

  assign m_valid = (count != '0);

  fib_fifo #(
    .WIDTH (DATA_W + IDX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({term_in, idx_q}),
    .pop   (pop),
    .rdata ({m_data, m_index}),
    .count (count)
  );

endmodule

// File: tb/tb_fib_term_capture.sv
// Bench: two captures (DEPTH 4 and 13), each driving its own behavioural generator.
module tb_fib_term_capture;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] term_a, term_b, data_a, data_b;
  logic [4:0] index_a, index_b;
  logic restart_a, restart_b, valid_a, valid_b, wrap_a, wrap_b;
  logic ready_a = 1'b0, ready_b = 1'b0;

  fib_term_capture #(.DATA_W(8), .IDX_W(5), .DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .term_in(term_a), .gen_restart(restart_a), .m_valid(valid_a),
    .m_ready(ready_a), .m_data(data_a), .m_index(index_a), .seq_wrap(wrap_a)
  );

  fib_term_capture #(.DATA_W(8), .IDX_W(5), .DEPTH(13)) dut_b (
    .clk(clk), .rst_n(rst_n), .term_in(term_b), .gen_restart(restart_b), .m_valid(valid_b),
    .m_ready(ready_b), .m_data(data_b), .m_index(index_b), .seq_wrap(wrap_b)
  );

  // Generators: load 1,1 on a restart edge, otherwise advance (mod 256).
  logic [7:0] nxt_a = 8'd0, nxt_b = 8'd0;
  initial begin term_a = 8'd0; term_b = 8'd0; end
  always @(posedge clk) begin
    if (restart_a) begin term_a <= 8'd1; nxt_a <= 8'd1; end
    else begin term_a <= nxt_a; nxt_a <= term_a + nxt_a; end
    if (restart_b) begin term_b <= 8'd1; nxt_b <= 8'd1; end
    else begin term_b <= nxt_b; nxt_b <= term_b + nxt_b; end
  end

  int checks = 0;
  int errors = 0;
  int fib_tab [13] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
    end
  endtask

  // Model of instance A: mode 0 restart, 1 stream, 2 wait; FIFO as a queue.
  int m_mode, m_idx, m_res, m_prev;
  int qd[$], qi[$];

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_res = 0; m_prev = 0;
    qd.delete(); qi.delete();
  endtask

  task automatic model_step(input int t, input bit rdy);
    bit full, pop, push;
    full = (qd.size() == 4);
    pop  = (qd.size() != 0) && rdy;
    push = 1'b0;
    if (m_mode == 0) begin
      m_mode = 1; m_idx = 0;
    end else if (m_mode == 1) begin
      if (m_idx >= 1 && t < m_prev) begin m_res = 0; m_mode = 0; end
      else if (m_idx >= m_res && full) begin m_res = m_idx; m_mode = 2; end
      else if (m_idx >= m_res) push = 1'b1;
      if (push) begin qd.push_back(t); qi.push_back(m_idx); end
      m_prev = t;
      m_idx = (m_idx < 31) ? m_idx + 1 : 31;
    end else if (!full) begin
      m_mode = 0;
    end
    if (pop) begin void'(qd.pop_front()); void'(qi.pop_front()); end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step(int'(term_a), ready_a);
    end
  end

  // Compare process: cycle model for A; gap-free series order for both consumers.
  int exp_a = 0, exp_b = 0;
  logic [12:0] pops_a[$], pops_b[$];
  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_a = 0; exp_b = 0;
        pops_a.delete(); pops_b.delete();
      end else begin
        chk("a_gen_restart", {31'd0, restart_a}, {31'd0, m_mode == 0});
        chk("a_m_valid", {31'd0, valid_a}, {31'd0, qd.size() != 0});
        chk("a_seq_wrap", {31'd0, wrap_a},
            {31'd0, m_mode == 1 && m_idx >= 1 && int'(term_a) < m_prev});
        if (qd.size() != 0) begin
          chk("a_m_data", {24'd0, data_a}, qd[0]);
          chk("a_m_index", {27'd0, index_a}, qi[0]);
        end
        if (valid_a && ready_a) begin
          chk("a_series_index", {27'd0, index_a}, exp_a);
          chk("a_series_data", {24'd0, data_a}, fib_tab[exp_a]);
          pops_a.push_back({data_a, index_a});
          exp_a = (exp_a + 1) % 13;
        end
        if (valid_b && ready_b) begin
          chk("b_series_index", {27'd0, index_b}, exp_b);
          chk("b_series_data", {24'd0, data_b}, fib_tab[exp_b]);
          pops_b.push_back({data_b, index_b});
          exp_b = (exp_b + 1) % 13;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int rs_a[$];
  int ws_a[$];
  int rs_b[$];
  int ws_b[$];
  logic [63:0] pat;

  initial begin
    // Reset state
    ready_a = 1'b1; ready_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_valid", {31'd0, valid_a}, 0);
    chk("rst_a_data", {24'd0, data_a}, 0);
    chk("rst_a_index", {27'd0, index_a}, 0);
    chk("rst_a_wrap", {31'd0, wrap_a}, 0);
    chk("rst_a_restart", {31'd0, restart_a}, 1);
    chk("rst_b_valid", {31'd0, valid_b}, 0);
    chk("rst_b_restart", {31'd0, restart_b}, 1);
    rst_n = 1'b1;

    // A streams freely; B fills its 13 entries, wraps, then waits
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (c == 0) chk("a_latency_empty", {31'd0, valid_a}, 0);
      if (c == 1) begin
        chk("a_first_valid", {31'd0, valid_a}, 1);
        chk("a_first_data", {24'd0, data_a}, 1);
        chk("a_first_index", {27'd0, index_a}, 0);
      end
      if (restart_a) rs_a.push_back(c);
      if (wrap_a) ws_a.push_back(c);
      if (restart_b) rs_b.push_back(c);
      if (wrap_b) ws_b.push_back(c);
    end
    chk("a_restart_count", rs_a.size(), 2);
    chk("a_first_restart", rs_a[0], 14);
    chk("a_period", rs_a[1] - rs_a[0], 15);
    chk("a_wrap_count", ws_a.size(), 2);
    chk("a_wrap_cycle", ws_a[0], 13);
    chk("b_wrap_count", ws_b.size(), 1);
    chk("b_wrap_cycle", ws_b[0], 13);
    chk("b_restart_count", rs_b.size(), 1);
    chk("b_restart_cycle", rs_b[0], 14);
    chk("b_wait_valid", {31'd0, valid_b}, 1);
    chk("b_wait_data", {24'd0, data_b}, 1);
    chk("b_wait_index", {27'd0, index_b}, 0);

    // Drain B: after idx 12 the next delivered term is idx 0
    ready_b = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("b_drain_count", {31'd0, pops_b.size() >= 14}, 1);
    chk("b_after_wrap_data", {24'd0, pops_b[13][12:5]}, 1);
    chk("b_after_wrap_index", {27'd0, pops_b[13][4:0]}, 0);

    // A backpressured from reset: stalled head held, then resumes at idx 4
    ready_a = 1'b0;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      @(posedge clk); #1;
      if (c >= 1 && c <= 5) begin
        chk("a_stall_valid", {31'd0, valid_a}, 1);
        chk("a_stall_data", {24'd0, data_a}, 1);
        chk("a_stall_index", {27'd0, index_a}, 0);
      end
      if (c == 12) ready_a = 1'b1;
    end
    chk("a_resume_count", {31'd0, pops_a.size() >= 7}, 1);
    chk("a_resume_data4", {24'd0, pops_a[4][12:5]}, 5);
    chk("a_resume_index4", {27'd0, pops_a[4][4:0]}, 4);
    chk("a_resume_data6", {24'd0, pops_a[6][12:5]}, 13);
    chk("a_resume_index6", {27'd0, pops_a[6][4:0]}, 6);

    // Irregular consumer: exercises push+pop at count 3 and repeated WAIT cycles
    pat = 64'hB63C_A5F0_0F5A_C369;
    for (int c = 0; c < 64; c++) begin
      @(posedge clk); #1;
      ready_a = pat[c];
    end

    // Asynchronous reset at idx 7 with two entries queued
    ready_a = 1'b1;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c == 6) ready_a = 1'b0;
    end
    chk("a_prerst_valid", {31'd0, valid_a}, 1);
    chk("a_prerst_index", {27'd0, index_a}, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("a_async_valid", {31'd0, valid_a}, 0);
    chk("a_async_restart", {31'd0, restart_a}, 1);
    ready_a = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("a_postrst_count", {31'd0, pops_a.size() >= 1}, 1);
    chk("a_postrst_data", {24'd0, pops_a[0][12:5]}, 1);
    chk("a_postrst_index", {27'd0, pops_a[0][4:0]}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
